wptr_full_gen: RTL and testbench
================================

WPTR_FULL_GEN -- requirements
Module: wptr_full_gen

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 3, giving address width; FIFO depth is 2**PTR_WIDTH and pointers are PTR_WIDTH+1 bits.
REQ-002 SHALL have parameter AF_THRESH, default 6, giving the almost-full level threshold.
REQ-003 SHALL have port clk  input  1  write-domain clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port winc  input  1  write request.
REQ-006 SHALL have port wq2_rptr  input  PTR_WIDTH+1  Gray read pointer, already synchronized into the clk domain.
REQ-007 SHALL have port wen  output  1  memory write enable = winc & ~wfull (combinational).
REQ-008 SHALL have port waddr  output  PTR_WIDTH  binary write address = low PTR_WIDTH bits of the binary pointer.
REQ-009 SHALL have port wptr  output  PTR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-010 SHALL have port wfull  output  1  registered full flag.
REQ-011 SHALL have port wlevel  output  PTR_WIDTH+1  registered fill level, 0..2**PTR_WIDTH.
REQ-012 SHALL have port wovf  output  1  sticky overflow flag.
REQ-013 SHALL have port walmost_full  output  1  registered almost-full flag.

Function
REQ-014 SHALL hold a PTR_WIDTH+1-bit binary pointer wbin; wbin_next = wbin + wen, modulo 2**(PTR_WIDTH+1).
REQ-015 SHALL compute wgray_next = (wbin_next >> 1) ^ wbin_next and register it into wptr on the same edge that wbin updates; wptr changes by exactly one bit per accepted write.
REQ-016 SHALL register wfull = (wgray_next == wq2_rptr with its two MSBs inverted); wfull asserts on the edge that accepts the write filling the last entry.
REQ-017 SHALL ignore winc while wfull=1: wbin, wptr and waddr hold, and wen=0.
REQ-018 SHALL set wovf on any edge where winc=1 and wfull=1; wovf stays set until reset.
REQ-019 SHALL register wlevel = wbin_next - gray2bin(wq2_rptr), modulo 2**(PTR_WIDTH+1); the value is conservative (it lags real reads by synchronizer latency).
REQ-020 SHALL deassert wfull and lower wlevel one clk after wq2_rptr advances. Simultaneous write and read advance SHALL use both wbin_next and the new wq2_rptr.
REQ-021 SHALL wrap wbin from 2**(PTR_WIDTH+1)-1 to 0 with no spurious wfull; full is detected only by the MSB-inverted Gray compare.
REQ-022 SHALL have one-cycle latency from an accepted winc to wptr, wfull, wlevel and walmost_full.

Reset
REQ-023 SHALL, while rst=1, asynchronously force wbin=0, wptr=0, waddr=0, wfull=0, wlevel=0, wovf=0 and walmost_full=0.
REQ-024 SHALL accept the first write on the first posedge clk after rst deasserts.
REQ-025 SHALL, on reset mid-operation, discard all pointer state immediately; the read side is reset by the system at the same time.

Configuration
REQ-026 SHALL, with macro WPTR_ALMOST_FULL_EN defined, register walmost_full = (next wlevel >= AF_THRESH).
REQ-027 SHALL, without WPTR_ALMOST_FULL_EN, keep the walmost_full port and tie it to 0, and include no threshold logic.

Structure
REQ-028 SHALL place the default PTR_WIDTH value and the bin2gray and gray2bin functions in the shared package fifo_pkg, so the read-side pointer block can reuse them.
REQ-029 SHALL instantiate one sub-module, gray_to_bin, parameterized by PTR_WIDTH, to convert wq2_rptr for the level calculation.
REQ-030 SHALL contain no synchronizer; wq2_rptr comes from the existing two-flop synchronizer.

Verification (PTR_WIDTH=3, AF_THRESH=6)
REQ-031 SHALL cover: rst pulse mid-stream -> all outputs 0 immediately, and the first write after release gives waddr=1, wptr=4'b0001.
REQ-032 SHALL cover: wq2_rptr=0 with 8 consecutive winc -> waddr 0..7, wptr 0,1,3,2,6,7,5,4,4'b1100, wfull=1 and wlevel=8 on the 8th edge.
REQ-033 SHALL cover: at full, winc=1 for 2 cycles -> wen=0, wptr holds 4'b1100, wovf=1 and stays 1 afterwards.
REQ-034 SHALL cover: at full, set wq2_rptr=4'b0010 (read count 3) -> next edge wfull=0, wlevel=5.
REQ-035 SHALL cover: 16 writes with wq2_rptr tracking -> wbin wraps 15->0, wptr goes 4'b1000->4'b0000, wfull never asserts.
REQ-036 SHALL cover: the 6th write from empty -> walmost_full=1 with WPTR_ALMOST_FULL_EN defined, and stays 0 without it.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers: default width and Gray/binary conversion.
// Read- and write-side pointer blocks both import this package.
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 3;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_gen_gray_to_bin.sv
// Combinational Gray-to-binary converter for a PTR_WIDTH+1 bit pointer.
// Used on the synchronized read pointer for the fill-level calculation.
module gray_to_bin
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF
) (
    input  logic [PTR_WIDTH:0] gray,
    output logic [PTR_WIDTH:0] bin
);

    logic [31:0] bin_w;

    assign bin_w = gray2bin(32'(gray));
    assign bin   = bin_w[PTR_WIDTH:0];

endmodule

// File: rtl/wptr_full_gen.sv
// Write-side pointer, full, level and overflow generator for an async FIFO.
// Define WPTR_ALMOST_FULL_EN to enable the registered almost-full flag.
module wptr_full_gen
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF,
    parameter int AF_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 winc,
    input  logic [PTR_WIDTH:0]   wq2_rptr,
    output logic                 wen,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   wptr,
    output logic                 wfull,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 wovf,
    output logic                 walmost_full
);

    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] wbin_next;
    logic [PTR_WIDTH:0] wgray_next;
    logic [PTR_WIDTH:0] rbin;
    logic [PTR_WIDTH:0] rptr_full;
    logic [PTR_WIDTH:0] wlevel_next;
    logic [31:0]        gray_w;
    logic               wfull_next;

    gray_to_bin #(
        .PTR_WIDTH(PTR_WIDTH)
    ) u_g2b (
        .gray(wq2_rptr),
        .bin (rbin)
    );

    assign wen        = winc & ~wfull;
    assign wbin_next  = wbin + {{PTR_WIDTH{1'b0}}, wen};
    assign gray_w     = bin2gray(32'(wbin_next));
    assign wgray_next = gray_w[PTR_WIDTH:0];
    assign waddr      = wbin[PTR_WIDTH-1:0];

    // Full when the writer is exactly one lap ahead: Gray MSB pair inverted
    assign rptr_full = {~wq2_rptr[PTR_WIDTH:PTR_WIDTH-1],
                        wq2_rptr[PTR_WIDTH-2:0]};
    assign wfull_next  = (wgray_next == rptr_full);
    assign wlevel_next = wbin_next - rbin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wlevel <= '0;
            wovf   <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            wfull  <= wfull_next;
            wlevel <= wlevel_next;
            wovf   <= wovf | (winc & wfull);
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [PTR_WIDTH:0] AF_LVL = AF_THRESH[PTR_WIDTH:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walmost_full <= 1'b0;
        end else begin
            walmost_full <= (wlevel_next >= AF_LVL);
        end
    end
`else
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Scoreboard bench for wptr_full_gen: counts-based model, random + directed.
// Build with WPTR_ALMOST_FULL_EN to check the almost-full flag as well.
module tb_wptr_full_gen;

    typedef struct {
        logic       chk_wen;
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wptr;
        logic       wfull;
        logic [3:0] wlevel;
        logic       wovf;
        logic       waf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic [3:0] wq2_rptr;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic [3:0] wlevel;
    logic       wovf;
    logic       walmost_full;

    int errors = 0;
    int checks = 0;
    bit done = 0;

    exp_t qn[$];
    exp_t qp[$];

    // model: total writes accepted, reads seen via synchronized pointer
    int   wc, rc;
    bit   m_full, m_ovf;
    exp_t cur;

    always #5 clk = ~clk;

    wptr_full_gen #(
        .PTR_WIDTH(3),
        .AF_THRESH(6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .winc        (winc),
        .wq2_rptr    (wq2_rptr),
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .wfull       (wfull),
        .wlevel      (wlevel),
        .wovf        (wovf),
        .walmost_full(walmost_full)
    );

    function automatic logic [3:0] gray(input int v);
        int b;
        b = v % 16;
        return 4'((b >> 1) ^ b);
    endfunction

    function automatic exp_t state_of(input int w, input int r,
                                      input bit f, input bit o);
        exp_t e;
        int   lvl;
        lvl       = w - r;
        e.chk_wen = 1'b0;
        e.wen     = 1'b0;
        e.waddr   = 3'(w % 8);
        e.wptr    = gray(w);
        e.wfull   = f;
        e.wlevel  = 4'(lvl);
        e.wovf    = o;
`ifdef WPTR_ALMOST_FULL_EN
        e.waf     = (lvl >= 6);
`else
        e.waf     = 1'b0;
`endif
        return e;
    endfunction

    // One clock: drive at negedge, push expectations for now and post-edge
    task automatic cycle(input bit r, input bit inc, input int rnew);
        exp_t e;
        @(negedge clk);
        rst  = r;
        winc = inc;
        if (r) begin
            wc = 0; rc = 0; m_full = 0; m_ovf = 0;
            wq2_rptr = 4'd0;
            cur = state_of(0, 0, 0, 0);
            e = cur;
            e.chk_wen = 1'b1;
            e.wen = inc;
            qn.push_back(e);
            qp.push_back(cur);
        end else begin
            rc = rnew;
            wq2_rptr = gray(rc);
            e = cur;
            e.chk_wen = 1'b1;
            e.wen = inc && !m_full;
            qn.push_back(e);
            if (inc && m_full) m_ovf = 1;
            if (inc && !m_full) wc++;
            m_full = ((wc - rc) == 8);
            cur = state_of(wc, rc, m_full, m_ovf);
            qp.push_back(cur);
        end
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic check_state(input string ph, input exp_t e);
        if (e.chk_wen) cmp({ph, ".wen"}, int'(wen), int'(e.wen));
        cmp({ph, ".waddr"},  int'(waddr),        int'(e.waddr));
        cmp({ph, ".wptr"},   int'(wptr),         int'(e.wptr));
        cmp({ph, ".wfull"},  int'(wfull),        int'(e.wfull));
        cmp({ph, ".wlevel"}, int'(wlevel),       int'(e.wlevel));
        cmp({ph, ".wovf"},   int'(wovf),         int'(e.wovf));
        cmp({ph, ".waf"},    int'(walmost_full), int'(e.waf));
    endtask

    // Monitor: settled combinational/immediate view, then post-edge view
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (qn.size() == 0) begin
                errors++;
                $display("FAIL qn_empty at %0t", $time);
            end else begin
                e = qn.pop_front();
                check_state("pre", e);
            end
            @(posedge clk);
            #1;
            if (qp.size() == 0) begin
                errors++;
                $display("FAIL qp_empty at %0t", $time);
            end else begin
                e = qp.pop_front();
                check_state("post", e);
            end
        end
    end

    initial begin
        int rn, adv, lim;
        rst = 1'b1;
        winc = 1'b0;
        wq2_rptr = 4'd0;
        wc = 0; rc = 0; m_full = 0; m_ovf = 0;
        cur = state_of(0, 0, 0, 0);

        cycle(1, 0, 0);
        cycle(1, 1, 0);
        // a few writes, then reset mid-stream, then first write after it
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        cycle(1, 0, 0);

        // fill from empty: 8 writes, read pointer parked at 0
        for (int i = 0; i < 8; i++) cycle(0, 1, 0);
        // write attempts while full -> overflow, pointer holds
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        // read side reports 3 entries consumed
        cycle(0, 0, 3);
        cycle(0, 0, 3);

        // drain-tracking writes across the pointer wrap
        cycle(0, 0, wc);
        for (int i = 0; i < 16; i++) cycle(0, 1, wc);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            lim = wc - rc;
            if (lim > 2) lim = 2;
            adv = (lim > 0) ? int'($urandom_range(0, lim)) : 0;
            if (($urandom % 4) == 0) adv = 0;
            rn = rc + adv;
            if (($urandom % 100) == 0) cycle(1, $urandom % 2, 0);
            else cycle(0, ($urandom % 4) != 0, rn);
        end

        @(posedge clk);
        #5;
        done = 1;
        checks++;
        if (qn.size() != 0 || qp.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got %0d/%0d expected 0/0",
                     qn.size(), qp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
